odd_even_clk_div: RTL and testbench
===================================

Name: odd_even_clk_div

Overview:
- Programmable-ratio clock divider; parametrised successor to the fixed odd-ratio divider.
- Produces a 50%-duty divided clock `dout` for any integer ratio N >= 2, odd or even.
- Ratio can be changed at run time, glitch-free, at period boundaries; adds enable, a period strobe and error reporting.
- Sits in the clock-generation area and feeds the derived clocks and strobes used by downstream test blocks.

Parameters:
- DIV_W, 8: width of the divisor and the internal counter; legal N range is 2 to 2^DIV_W-1.
- DEFAULT_DIV, 5: active divisor after reset; must be >= 2.

Ports:
- clk  in  1  reference clock; all state on posedge except one negedge half-cycle flop.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  divider enable.
- div_in  in  DIV_W  requested divisor.
- div_load  in  1  one-cycle strobe; captures div_in.
- dout  out  1  divided clock.
- period_tick  out  1  one-clk-cycle strobe at each output period start.
- cur_div  out  DIV_W  divisor in force for the current period.
- div_err  out  1  one-cycle pulse when an illegal divisor is loaded.

Behaviour:
- Reset (rst=0, asynchronous):
  - dout=0, period_tick=0, div_err=0.
  - cur_div=DEFAULT_DIV, pending divisor cleared.
  - Counter set to cur_div-1, so the first enabled posedge is a period boundary.
  - Negedge flop cleared.
- Counter: increments 0..cur_div-1 on each posedge while en=1, then wraps to 0. The posedge where it becomes 0 is the period boundary.
- Period start: dout rises on the boundary posedge. Period length is N clk cycles.
- Even N: dout is high for N/2 cycles; it falls on the posedge where the counter becomes N/2.
- Odd N:
  - Posedge term p is high for counter 0..(N-3)/2.
  - Negedge term n is p sampled on the clk falling edge.
  - dout = p OR n, so dout is high for exactly N/2 clk periods and falls on the negedge following posedge (N-1)/2.
  - N=3: high from posedge 0 to negedge 1.
- period_tick: high during the clk cycle that starts at each boundary posedge.
- cur_div: updates at the boundary edge.
- Divisor loading:
  - A div_load with 2 <= div_in is stored as pending; if several loads occur before a boundary, the last one wins.
  - The pending value becomes cur_div at the first boundary strictly after the capture edge. The period already in progress completes with the old N.
  - A load coinciding with a boundary edge applies at the next boundary.
  - While the divider is stopped (en=0, idle), a load is applied on the capture edge.
- Illegal load: div_in of 0 or 1 is rejected. div_err pulses high for one cycle after the capture edge; cur_div and pending are unchanged.
- Glitch-free: dout never has a high or low phase shorter than min(old,new)/2 cycles across a ratio change.
- en=1 again after a stop: the next posedge is a boundary, with the same behaviour as after reset.
- Reset mid-period: immediately forces the reset values; any pending divisor is discarded.

Optional Feature:
- Macro: GRACEFUL_STOP_EN.
- Defined:
  - Deasserting en lets the current period complete.
  - The counter then parks at cur_div-1 with dout=0.
  - No period_tick is issued for a period that will not run.
  - en reasserted before the boundary cancels the stop with no disturbance.
- Undefined:
  - At the first posedge with en=0, the counter is forced to cur_div-1 and p=0.
  - dout drops within that cycle; with odd N the negedge term clears at the next negedge.
  - A truncated high phase is permitted.

Test Plan:
- Reset release, en=1, clk 10 ns, default N=5:
  - dout period 50 ns, high 25 ns.
  - Rises on posedge, falls on negedge.
  - period_tick every 5 cycles.
  - cur_div=5.
- Load 4 then, separately, 3:
  - N=4 gives high 20 ns / low 20 ns.
  - N=3 gives high 15 ns / period 30 ns.
  - cur_div changes only on the boundary edge.
- Load 8 in cycle 2 of an N=5 period:
  - That period still lasts 50 ns.
  - The next period is 80 ns.
  - Two loads (8 then 6) in the same period leave N=6 in force.
- div_in=1 and div_in=0 loaded:
  - div_err pulses one cycle each.
  - cur_div and dout are unchanged.
- en dropped mid-high phase, N=7:
  - Macro undefined: dout low within one cycle.
  - Macro defined: the period runs its full 70 ns, then dout stays 0.
  - In both cases, reasserting en gives a rising edge on the next posedge.
- rst pulled low asynchronously between clk edges mid-period:
  - dout=0 and cur_div=5 immediately.
  - A pending load is lost.

Source files
------------

// File: rtl/odd_even_clk_div.sv
// odd_even_clk_div: programmable-ratio 50%-duty clock divider for N >= 2.
// Divisor changes are queued and applied only at period boundaries, so dout
// never shows a runt phase. Odd ratios add a falling-edge half-cycle term.
// Build option: define GRACEFUL_STOP_EN to let the running period finish
// after en drops; without it the divider stops on the first posedge with en=0.
// There is no valid/ready handshake: div_load is a single-cycle strobe that is
// always accepted and needs no acknowledge; div_err reports a rejected value.
module odd_even_clk_div #(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
    output logic             dout,
    output logic             period_tick,
    output logic [DIV_W-1:0] cur_div,
    output logic             div_err
);

    localparam logic [DIV_W-1:0] LP_ONE = DIV_W'(1);
    localparam logic [DIV_W-1:0] LP_TWO = DIV_W'(2);
    localparam logic [DIV_W-1:0] LP_DEF = DIV_W'(DEFAULT_DIV);

    // ST_IDLE: counter parked at cur_div-1, the next enabled posedge starts a period.
    // ST_RUN:  a period is in progress.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] r_cur_div;
    logic [DIV_W-1:0] w_cur_div_nxt;
    logic [DIV_W-1:0] r_pend;
    logic [DIV_W-1:0] w_pend_nxt;
    logic             r_pend_vld;
    logic             w_pend_vld_nxt;
    logic             r_p;
    logic             w_p_nxt;
    logic             r_n;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_err;
    logic             w_load_ok;
    logic             w_load_bad;
    logic             w_last;
    logic             w_bnd;
    logic             w_adv;

    assign w_load_ok  = div_load && (div_in >= LP_TWO);
    assign w_load_bad = div_load && (div_in < LP_TWO);
    assign w_last     = (r_cnt == (r_cur_div - LP_ONE));

    // Next-state: decide boundary / advance / stop, then divisor, counter and p term.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_cur_div_nxt  = r_cur_div;
        w_pend_nxt     = r_pend;
        w_pend_vld_nxt = r_pend_vld;
        w_tick_nxt     = 1'b0;
        w_bnd          = 1'b0;
        w_adv          = 1'b0;

        // Legal loads land in the pending slot; last one before a boundary wins.
        if (w_load_ok) begin
            w_pend_nxt     = div_in;
            w_pend_vld_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_bnd       = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
`ifdef GRACEFUL_STOP_EN
                if (w_last && !en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_bnd = 1'b1;
                end else begin
                    w_adv = 1'b1;
                end
`else
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_last) begin
                    w_bnd = 1'b1;
                end else begin
                    w_adv = 1'b1;
                end
`endif
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        if (w_bnd) begin
            // A load captured on this very edge stays pending for the next boundary.
            if (r_pend_vld) begin
                w_cur_div_nxt  = r_pend;
                w_pend_vld_nxt = w_load_ok;
            end
            w_cnt_nxt  = '0;
            w_tick_nxt = 1'b1;
        end else if (w_adv) begin
            w_cnt_nxt = r_cnt + LP_ONE;
        end else if (r_state == ST_IDLE) begin
            // Stopped: nothing is running, so a new ratio can take effect at once.
            if (w_load_ok) begin
                w_cur_div_nxt  = div_in;
                w_pend_vld_nxt = 1'b0;
            end else if (r_pend_vld) begin
                w_cur_div_nxt  = r_pend;
                w_pend_vld_nxt = 1'b0;
            end
            w_cnt_nxt = w_cur_div_nxt - LP_ONE;
        end else begin
            w_cnt_nxt = r_cur_div - LP_ONE;
        end

        // p covers counts 0..floor(N/2)-1; for odd N the negedge term adds the half cycle.
        w_p_nxt = (w_bnd || w_adv) && (w_cnt_nxt < (w_cur_div_nxt >> 1));
    end

    // Posedge state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= LP_DEF - LP_ONE;
            r_cur_div  <= LP_DEF;
            r_pend     <= '0;
            r_pend_vld <= 1'b0;
            r_p        <= 1'b0;
            r_tick     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_cur_div  <= w_cur_div_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_vld <= w_pend_vld_nxt;
            r_p        <= w_p_nxt;
            r_tick     <= w_tick_nxt;
            r_err      <= w_load_bad;
        end
    end

    // Falling-edge copy of p that stretches the odd-ratio high phase by half a cycle.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_n <= 1'b0;
        end else begin
            r_n <= r_p;
        end
    end

    assign dout        = r_p | (r_n & r_cur_div[0]);
    assign period_tick = r_tick;
    assign cur_div     = r_cur_div;
    assign div_err     = r_err;

endmodule

// File: tb/tb_odd_even_clk_div.sv
// tb_odd_even_clk_div: directed ratio/stop/reset scenarios followed by random
// traffic, checked against a period-level model of the divider.
module tb_odd_even_clk_div;

    localparam int DIV_W       = 8;
    localparam int DEFAULT_DIV = 5;

    logic             clk      = 1'b0;
    logic             rst      = 1'b1;
    logic             en       = 1'b0;
    logic             div_load = 1'b0;
    logic [DIV_W-1:0] div_in   = '0;
    logic             dout;
    logic             period_tick;
    logic             div_err;
    logic [DIV_W-1:0] cur_div;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  chk_on   = 1'b0;

    // Model: ratio in force, position inside the period, pending ratio.
    int  m_n;
    int  m_pos;
    bit  m_run;
    bit  m_pv;
    int  m_pend;
    // Expected outputs for the clk cycle following the latest posedge.
    bit  e_h0;
    bit  e_h1;
    bit  e_tick;
    bit  e_err;
    int  e_cur;

    time t_rise      = 0;
    time t_prev_rise = 0;
    time t_fall      = 0;
    time t_stop      = 0;

    odd_even_clk_div #(
        .DIV_W       (DIV_W),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .div_in      (div_in),
        .div_load    (div_load),
        .dout        (dout),
        .period_tick (period_tick),
        .cur_div     (cur_div),
        .div_err     (div_err)
    );

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    // Edge timestamps of the divided clock.
    always @(posedge dout) begin
        t_prev_rise = t_rise;
        t_rise      = $time;
    end
    always @(negedge dout) t_fall = $time;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_n    = DEFAULT_DIV;
        m_pos  = DEFAULT_DIV - 1;
        m_run  = 1'b0;
        m_pv   = 1'b0;
        m_pend = 0;
        e_h0   = 1'b0;
        e_h1   = 1'b0;
        e_tick = 1'b0;
        e_err  = 1'b0;
        e_cur  = DEFAULT_DIV;
    endtask

    // One posedge of the model. dout is high for the first N half-cycles of
    // each N-cycle period; half-cycle h of cycle pos is h = 2*pos or 2*pos+1.
    task automatic model_step(input bit s_en, input bit s_load, input int s_din);
        bit legal;
        bit stop_trunc;
        bit applied;
        bit prev_h1;
        legal      = s_load && (s_din >= 2);
        stop_trunc = 1'b0;
        applied    = 1'b0;
        prev_h1    = e_h1;
        e_tick     = 1'b0;
        if (!m_run) begin
            if (s_en) begin
                if (m_pv) begin m_n = m_pend; m_pv = 1'b0; end
                m_pos  = 0;
                m_run  = 1'b1;
                e_tick = 1'b1;
            end else if (legal) begin
                m_n = s_din; m_pv = 1'b0; applied = 1'b1;
            end else if (m_pv) begin
                m_n = m_pend; m_pv = 1'b0;
            end
        end else begin
`ifdef GRACEFUL_STOP_EN
            if (m_pos == m_n - 1 && !s_en) begin
                m_run = 1'b0;
            end else if (m_pos == m_n - 1) begin
`else
            if (!s_en) begin
                m_run      = 1'b0;
                stop_trunc = 1'b1;
            end else if (m_pos == m_n - 1) begin
`endif
                if (m_pv) begin m_n = m_pend; m_pv = 1'b0; end
                m_pos  = 0;
                e_tick = 1'b1;
            end else begin
                m_pos++;
            end
        end
        if (legal && !applied) begin
            m_pend = s_din;
            m_pv   = 1'b1;
        end
        e_err = s_load && (s_din < 2);
        e_cur = m_n;
        if (m_run) begin
            e_h0 = (2 * m_pos) < m_n;
            e_h1 = (2 * m_pos + 1) < m_n;
        end else begin
            // An abrupt stop leaves the odd-ratio half-cycle term up until the next negedge.
            e_h0 = stop_trunc && (m_n % 2 == 1) && prev_h1;
            e_h1 = 1'b0;
        end
    endtask

    // Driver: inputs change just after the negedge, model steps on the posedge.
    task automatic cycle(input bit c_en, input bit c_load, input int c_din);
        @(negedge clk);
        #1;
        en       = c_en;
        div_load = c_load;
        div_in   = DIV_W'(c_din);
        @(posedge clk);
        model_step(c_en, c_load, c_din);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst      = 1'b0;
        en       = 1'b0;
        div_load = 1'b0;
        model_reset();
        chk_on   = 1'b1;
        #1;
        chk("reset_dout", dout, 0);
        chk("reset_cur_div", cur_div, 5);
        chk("reset_period_tick", period_tick, 0);
        chk("reset_div_err", div_err, 0);
        @(posedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
    endtask

    // Run enabled until the model sits in the last cycle of a period.
    task automatic run_to_end();
        int guard;
        guard = 0;
        do begin
            cycle(1, 0, 0);
            guard++;
        end while (!(m_run && m_pos == m_n - 1) && guard < 600);
        if (guard >= 600) begin
            n_checks++;
            n_fail++;
            $display("FAIL run_to_end: period end not reached within 600 cycles");
        end
        #2;
    endtask

    task automatic measure_period(input string name, input int exp_hi, input int exp_per);
        run_to_end();
        run_to_end();
        chk({name, "_high"}, longint'(t_fall - t_rise), exp_hi);
        chk({name, "_period"}, longint'(t_rise - t_prev_rise), exp_per);
    endtask

    // Compare process: both half-cycles of dout plus the strobes and divisor.
    always begin
        @(posedge clk);
        #2;
        if (chk_on) begin
            chk("dout_first_half", dout, e_h0);
            chk("period_tick", period_tick, e_tick);
            chk("div_err", div_err, e_err);
            chk("cur_div", cur_div, e_cur);
        end
        @(negedge clk);
        #2;
        if (chk_on) chk("dout_second_half", dout, e_h1);
    end

    initial begin
        do_reset();

        // Default ratio 5 from reset.
        cycle(1, 0, 0);
        #2;
        chk("first_tick", period_tick, 1);
        chk("first_rise", dout, 1);
        measure_period("n5", 25, 50);
        chk("n5_cur_div", cur_div, 5);

        // Ratio 4, then ratio 3.
        cycle(1, 1, 4);
        run_to_end();
        measure_period("n4", 20, 40);
        cycle(1, 1, 3);
        run_to_end();
        measure_period("n3", 15, 30);

        // Load 8 in cycle 2 of a ratio-5 period.
        cycle(1, 1, 5);
        run_to_end();
        run_to_end();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        cycle(1, 1, 8);
        run_to_end();
        cycle(1, 0, 0);
        #2;
        chk("n5_before_8_period", longint'(t_rise - t_prev_rise), 50);
        chk("n8_cur_div", cur_div, 8);
        run_to_end();
        measure_period("n8", 40, 80);

        // Two loads in one period: the last one wins.
        cycle(1, 0, 0);
        cycle(1, 1, 8);
        cycle(1, 1, 6);
        run_to_end();
        measure_period("n6", 30, 60);
        chk("n6_cur_div", cur_div, 6);

        // Illegal divisors.
        cycle(1, 1, 1);
        #2;
        chk("err_div1", div_err, 1);
        chk("err_div1_cur", cur_div, 6);
        cycle(1, 1, 0);
        #2;
        chk("err_div0", div_err, 1);
        chk("err_div0_cur", cur_div, 6);
        cycle(1, 0, 0);
        #2;
        chk("err_clears", div_err, 0);

        // Drop en in the high phase with ratio 7.
        cycle(1, 1, 7);
        run_to_end();
        run_to_end();
        cycle(1, 0, 0);
        cycle(1, 0, 0);
`ifdef GRACEFUL_STOP_EN
        repeat (8) cycle(0, 0, 0);
        #2;
        chk("stop_dout_low", dout, 0);
        chk("stop_full_high", longint'(t_fall - t_rise), 35);
`else
        cycle(0, 0, 0);
        t_stop = $time;
        cycle(0, 0, 0);
        #2;
        chk("stop_dout_low", dout, 0);
        chk("stop_fall_within_cycle", longint'((t_fall >= t_stop) && (t_fall - t_stop <= 10)), 1);
`endif
        cycle(0, 1, 3);
        #2;
        chk("idle_load_applies", cur_div, 3);
        cycle(1, 0, 0);
        #2;
        chk("restart_rise", dout, 1);
        chk("restart_tick", period_tick, 1);

        // Asynchronous reset mid-period discards a pending ratio.
        cycle(1, 1, 9);
        cycle(1, 0, 0);
        do_reset();
        cycle(1, 0, 0);
        #2;
        chk("pending_lost", cur_div, 5);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end
            cycle($urandom_range(0, 9) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 12));
        end

        #3;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
